// File: rtl/hpdl_pkg.sv
// Shared constants and types for the HPDL-1414 line editor and its character classifier.
package hpdl_pkg;

    localparam logic [7:0] CH_BKSP     = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [6:0] CH_SPACE    = 7'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h5F;
    localparam logic [7:0] CH_LOWER_LO = 8'h61;
    localparam logic [7:0] CH_LOWER_HI = 8'h7A;
    localparam logic [7:0] CASE_FOLD   = 8'h20;

    typedef enum logic [2:0] {
        CLS_PRINT,
        CLS_BKSP,
        CLS_CR,
        CLS_FF,
        CLS_BAD
    } char_class_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } ed_state_t;

endpackage

// File: rtl/hpdl_char_map.sv
// Combinational byte classifier: maps a received byte to its class and the 7-bit HPDL code.
module hpdl_char_map
    import hpdl_pkg::*;
(
    input  logic [7:0]  rx_byte,
    output char_class_t char_cls,
    output logic [6:0]  char_code
);

    logic [7:0] folded;

    always_comb begin
        char_cls  = CLS_BAD;
        char_code = CH_SPACE;
        folded    = rx_byte - CASE_FOLD;
        if (rx_byte >= CH_PRINT_LO && rx_byte <= CH_PRINT_HI) begin
            char_cls  = CLS_PRINT;
            char_code = rx_byte[6:0];
        end else if (rx_byte >= CH_LOWER_LO && rx_byte <= CH_LOWER_HI) begin
            // the display has no lowercase glyphs, so fold onto the uppercase ones
            char_cls  = CLS_PRINT;
            char_code = folded[6:0];
        end else begin
            case (rx_byte)
                CH_BKSP: char_cls = CLS_BKSP;
                CH_CR:   char_cls = CLS_CR;
                CH_FF:   char_cls = CLS_FF;
                default: char_cls = CLS_BAD;
            endcase
        end
    end

endmodule

// File: rtl/hpdl_line_editor.sv
// Line editor between the UART receiver and the HPDL-1414 character memory:
// turns received bytes into registered memory writes and tracks the cursor.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for bytes; each strobe gives at most one write
// ST_CLEAR | writing spaces to every position, incoming bytes dropped
module hpdl_line_editor
    import hpdl_pkg::*;
#(
    parameter int DISPLAY_LENGTH = 16,
    parameter int ADDR_W         = 4,
    parameter int WRAP           = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [6:0]        wr_data_o,
    output logic [ADDR_W-1:0] cursor_o,
    output logic              busy_o,
    output logic              rx_drop_o
);

    localparam logic [ADDR_W-1:0] LAST_POS  = ADDR_W'(DISPLAY_LENGTH - 1);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
    localparam ed_state_t         RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    ed_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cursor_q, cursor_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [6:0]        wr_data_q, wr_data_d;
    logic              drop_q, drop_d;

    char_class_t       char_cls;
    logic [6:0]        char_code;

    hpdl_char_map u_char_map (
        .rx_byte   (rx_data_i),
        .char_cls  (char_cls),
        .char_code (char_code)
    );

    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            state_q   <= RST_STATE;
            cursor_q  <= '0;
            clr_cnt_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= CH_SPACE;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cursor_q  <= cursor_d;
            clr_cnt_q <= clr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            drop_q    <= drop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor_q;
        clr_cnt_d = clr_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        drop_d    = drop_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    case (char_cls)
                        CLS_PRINT: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = cursor_q;
                            wr_data_d = char_code;
                            if (cursor_q == LAST_POS)
                                cursor_d = (WRAP != 0) ? '0 : cursor_q;
                            else
                                cursor_d = cursor_q + ONE;
                        end
                        CLS_BKSP: begin
                            if (cursor_q != '0) begin
                                cursor_d  = cursor_q - ONE;
                                wr_en_d   = 1'b1;
                                wr_addr_d = cursor_q - ONE;
                                wr_data_d = CH_SPACE;
                            end
                        end
                        CLS_CR: cursor_d = '0;
                        CLS_FF: begin
                            cursor_d  = '0;
                            clr_cnt_d = '0;
                            state_d   = ST_CLEAR;
                        end
                        default: drop_d = 1'b1;
                    endcase
                end
            end
            ST_CLEAR: begin
                // one space per cycle; the count, not the cursor, walks the addresses
                wr_en_d   = 1'b1;
                wr_addr_d = clr_cnt_q;
                wr_data_d = CH_SPACE;
                cursor_d  = '0;
                if (rx_valid_i)
                    drop_d = 1'b1;
                if (clr_cnt_q == LAST_POS) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign cursor_o  = cursor_q;
    assign busy_o    = (state_q == ST_CLEAR);
    assign rx_drop_o = drop_q;

endmodule

// File: tb/tb_hpdl_line_editor.sv
// Bench for hpdl_line_editor: two instances (16 positions wrapping with clear-on-reset,
// 12 positions sticking without it) driven by the same stimulus and checked against a reference model.
module tb_hpdl_line_editor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic       we_a, busy_a, drop_a, we_b, busy_b, drop_b;
    logic [3:0] addr_a, cur_a, addr_b, cur_b;
    logic [6:0] data_a, data_b;

    always #5 clk = ~clk;

    hpdl_line_editor #(.DISPLAY_LENGTH(16), .ADDR_W(4), .WRAP(1), .CLEAR_ON_RESET(1)) dut_a (
        .CLK_i(clk), .RST_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .wr_en_o(we_a), .wr_addr_o(addr_a), .wr_data_o(data_a),
        .cursor_o(cur_a), .busy_o(busy_a), .rx_drop_o(drop_a)
    );

    hpdl_line_editor #(.DISPLAY_LENGTH(12), .ADDR_W(4), .WRAP(0), .CLEAR_ON_RESET(0)) dut_b (
        .CLK_i(clk), .RST_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .wr_en_o(we_b), .wr_addr_o(addr_b), .wr_data_o(data_b),
        .cursor_o(cur_b), .busy_o(busy_b), .rx_drop_o(drop_b)
    );

    int o_we[2], o_addr[2], o_data[2], o_cur[2], o_busy[2], o_drop[2];
    always_comb begin
        o_we[0] = int'(we_a);     o_we[1] = int'(we_b);
        o_addr[0] = int'(addr_a); o_addr[1] = int'(addr_b);
        o_data[0] = int'(data_a); o_data[1] = int'(data_b);
        o_cur[0] = int'(cur_a);   o_cur[1] = int'(cur_b);
        o_busy[0] = int'(busy_a); o_busy[1] = int'(busy_b);
        o_drop[0] = int'(drop_a); o_drop[1] = int'(drop_b);
    end

    // character memory as seen through the write port
    int cap_a[16];
    int cap_b[16];
    int bad_addr = 0;
    always @(posedge clk) begin
        if (we_a) begin
            cap_a[addr_a] <= int'(data_a);
            if (int'(addr_a) >= 16) bad_addr <= bad_addr + 1;
        end
        if (we_b) begin
            cap_b[addr_b] <= int'(data_b);
            if (int'(addr_b) >= 12) bad_addr <= bad_addr + 1;
        end
    end

    // reference model
    int len[2]  = '{16, 12};
    int wrap[2] = '{1, 0};
    int mcur[2], mdrop[2];
    int mmem[2][16];
    int ewe[2], eaddr[2], edata[2];
    int ebusy;

    int pass_cnt = 0;
    int check_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        check_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic model_step(input int b);
        ebusy = (b == 12) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            ewe[k] = 0;
            if ((b >= 32 && b <= 95) || (b >= 97 && b <= 122)) begin
                ewe[k]   = 1;
                eaddr[k] = mcur[k];
                edata[k] = (b >= 97) ? b - 32 : b;
                mmem[k][mcur[k]] = edata[k];
                if (wrap[k] != 0) mcur[k] = (mcur[k] + 1) % len[k];
                else if (mcur[k] + 1 < len[k]) mcur[k] = mcur[k] + 1;
            end else if (b == 8) begin
                if (mcur[k] > 0) begin
                    mcur[k]  = mcur[k] - 1;
                    ewe[k]   = 1;
                    eaddr[k] = mcur[k];
                    edata[k] = 32;
                    mmem[k][mcur[k]] = 32;
                end
            end else if (b == 13 || b == 12) begin
                mcur[k] = 0;
            end else begin
                mdrop[k] = 1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_we%0d", tag, k), o_we[k], ewe[k]);
            if (ewe[k] != 0) begin
                check($sformatf("%s_addr%0d", tag, k), o_addr[k], eaddr[k]);
                check($sformatf("%s_data%0d", tag, k), o_data[k], edata[k]);
            end
            check($sformatf("%s_cur%0d", tag, k), o_cur[k], mcur[k]);
            check($sformatf("%s_drop%0d", tag, k), o_drop[k], mdrop[k]);
            check($sformatf("%s_busy%0d", tag, k), o_busy[k], ebusy);
        end
    endtask

    // strobes on consecutive cycles; each result is checked one cycle after its strobe
    task automatic burst(input int q[$]);
        for (int i = 0; i < q.size(); i++) begin
            @(negedge clk);
            if (i > 0) check_outputs("burst");
            rx_valid = 1'b1;
            rx_data  = 8'(q[i]);
            model_step(q[i]);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        check_outputs("burst");
        ebusy = 0;
        ewe[0] = 0;
        ewe[1] = 0;
    endtask

    // follows a clear sequence from the current negedge until both instances are quiet
    task automatic wait_clear(input int inject, input int clr_a, input int clr_b);
        int nw[2], nb[2], seq_ok[2], clr[2];
        int done;
        nw = '{0, 0}; nb = '{0, 0}; seq_ok = '{1, 1}; clr = '{clr_a, clr_b};
        done = 0;
        for (int c = 0; c < 80 && done == 0; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (o_busy[k] != 0) nb[k]++;
                if (o_we[k] != 0) begin
                    if (o_addr[k] != nw[k] || o_data[k] != 32) seq_ok[k] = 0;
                    nw[k]++;
                end
            end
            if (c >= 2 && o_busy[0] == 0 && o_busy[1] == 0 && o_we[0] == 0 && o_we[1] == 0)
                done = 1;
            rx_valid = (c == inject);
            rx_data  = 8'h58;
            if (done == 0) @(negedge clk);
        end
        rx_valid = 1'b0;
        check("clear_finished", done, 1);
        for (int k = 0; k < 2; k++) begin
            if (clr[k] != 0) begin
                for (int a = 0; a < len[k]; a++) mmem[k][a] = 32;
                mcur[k] = 0;
                if (inject >= 0) mdrop[k] = 1;
            end
            check($sformatf("clear_writes%0d", k), nw[k], (clr[k] != 0) ? len[k] : 0);
            check($sformatf("clear_busy_cycles%0d", k), nb[k], (clr[k] != 0) ? len[k] : 0);
            check($sformatf("clear_order%0d", k), seq_ok[k], 1);
            check($sformatf("clear_cur%0d", k), o_cur[k], 0);
            check($sformatf("clear_drop%0d", k), o_drop[k], mdrop[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            mcur[k] = 0;
            mdrop[k] = 0;
            check($sformatf("rst_we%0d", k), o_we[k], 0);
            check($sformatf("rst_addr%0d", k), o_addr[k], 0);
            check($sformatf("rst_data%0d", k), o_data[k], 32);
            check($sformatf("rst_cur%0d", k), o_cur[k], 0);
            check($sformatf("rst_drop%0d", k), o_drop[k], 0);
        end
        check("rst_busy0", o_busy[0], 1);
        check("rst_busy1", o_busy[1], 0);
        rst = 1'b0;
        wait_clear(-1, 1, 0);
    endtask

    typedef struct {
        int din;
        int we;
        int addr;
        int data;
        int cur;
        int drop;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int q[$];
        int r, b, gap;

        for (int k = 0; k < 2; k++) begin
            mcur[k] = 0; mdrop[k] = 0; ewe[k] = 0; eaddr[k] = 0; edata[k] = 0;
            for (int a = 0; a < 16; a++) mmem[k][a] = 0;
        end
        for (int a = 0; a < 16; a++) begin
            cap_a[a] = 0;
            cap_b[a] = 0;
        end
        ebusy = 0;

        tbl[0] = '{din: 'h48, we: 1, addr: 0, data: 'h48, cur: 1, drop: 0};
        tbl[1] = '{din: 'h49, we: 1, addr: 1, data: 'h49, cur: 2, drop: 0};
        tbl[2] = '{din: 'h61, we: 1, addr: 2, data: 'h41, cur: 3, drop: 0};
        tbl[3] = '{din: 'h08, we: 1, addr: 2, data: 'h20, cur: 2, drop: 0};
        tbl[4] = '{din: 'h0D, we: 0, addr: 0, data: 0,     cur: 0, drop: 0};
        tbl[5] = '{din: 'h08, we: 0, addr: 0, data: 0,     cur: 0, drop: 0};
        tbl[6] = '{din: 'h07, we: 0, addr: 0, data: 0,     cur: 0, drop: 1};
        tbl[7] = '{din: 'h60, we: 0, addr: 0, data: 0,     cur: 0, drop: 1};

        do_reset();

        for (int i = 0; i < 8; i++) begin
            q = {tbl[i].din};
            burst(q);
            check($sformatf("tbl%0d_we", i), o_we[0], tbl[i].we);
            if (tbl[i].we != 0) begin
                check($sformatf("tbl%0d_addr", i), o_addr[0], tbl[i].addr);
                check($sformatf("tbl%0d_data", i), o_data[0], tbl[i].data);
            end
            check($sformatf("tbl%0d_cur", i), o_cur[0], tbl[i].cur);
            check($sformatf("tbl%0d_drop", i), o_drop[0], tbl[i].drop);
        end

        // fill to the last position, then one more printable: A wraps, B sticks
        q = {};
        for (int i = 0; i < 15; i++) q.push_back('h2E);
        burst(q);
        q = {'h61};
        burst(q);
        check("wrap_a_cur", o_cur[0], 0);
        check("stick_b_cur", o_cur[1], 11);
        q = {'h62};
        burst(q);
        check("stick_b_addr", o_addr[1], 11);
        check("stick_b_cur2", o_cur[1], 11);

        for (int n = 0; n < 40; n++) begin
            q = {};
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
                r = int'($urandom_range(0, 9));
                if (r < 5)       b = int'($urandom_range(32, 127));
                else if (r < 7)  b = 8;
                else if (r == 7) b = 13;
                else             b = int'($urandom_range(0, 255));
                if (b == 12) b = 13;
                q.push_back(b);
            end
            burst(q);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_outputs("gap");
            end
        end

        // clear with a byte arriving on the third clear cycle
        q = {'h0C};
        burst(q);
        wait_clear(2, 1, 1);

        for (int a = 0; a < 16; a++) check($sformatf("mem_a%0d", a), cap_a[a], mmem[0][a]);
        for (int a = 0; a < 12; a++) check($sformatf("mem_b%0d", a), cap_b[a], mmem[1][a]);
        check("addr_range", bad_addr, 0);

        q = {'h41, 'h42};
        burst(q);

        // reset in the middle of a clear restarts it from address 0
        q = {'h0C};
        burst(q);
        repeat (4) @(negedge clk);
        do_reset();
        q = {'h5A};
        burst(q);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
